// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
//   XlenDefault  : default operand/result width
//   mdu_op_e     : RV64M funct3 encodings
//   mdu_state_e  : sequencer states
//   is_div / is_signed_a / is_signed_b : op decode helpers
package mdu_pkg;

    localparam int unsigned XlenDefault = 64;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StResp
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op[2];
    endfunction

    // MUL keeps rs1 unsigned: its low half is identical either way.
    function automatic logic is_signed_a(mdu_op_e op);
        return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic is_signed_b(mdu_op_e op);
        return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV64M multiply/divide unit serving the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, on operand
// magnitudes; signs are applied in a single FIXUP cycle before the response.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   ex_req_valid_in/ex_req_ready_out request handshake (ready only in IDLE)
//   ex_req_op_in                     funct3 of the M-extension op
//   ex_operand1_in/ex_operand2_in    rs1 / rs2
//   ex_flush_in                      abandon any in-flight op
//   ex_resp_valid_out/ex_resp_ready_in response handshake
//   ex_mdu_result_out                registered result
//   ex_mdu_busy_out                  high whenever not IDLE
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_req_valid_in,
    output logic            ex_req_ready_out,
    input  logic [2:0]      ex_req_op_in,
    input  logic [XLEN-1:0] ex_operand1_in,
    input  logic [XLEN-1:0] ex_operand2_in,
    input  logic            ex_flush_in,
    output logic            ex_resp_valid_out,
    input  logic            ex_resp_ready_in,
    output logic [XLEN-1:0] ex_mdu_result_out,
    output logic            ex_mdu_busy_out
);

    localparam int unsigned CntW = $clog2(XLEN);

    mdu_state_e          state_q, state_d;
    mdu_op_e             op_q, op_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic                special_q, special_d;
    // Multiplicand for multiply, divisor magnitude for divide.
    logic [XLEN-1:0]     operand_q, operand_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
    // Special cases park their final value in the low half.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    mdu_op_e             req_op;
    logic                sign_a, sign_b;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                div_zero, div_ovf;
    logic [XLEN:0]       addend, sum;
    logic [XLEN:0]       rem_sh, rem_new;
    logic                rem_ge;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem;

    assign req_op = mdu_op_e'(ex_req_op_in);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        special_d = special_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        sign_a   = is_signed_a(req_op) && ex_operand1_in[XLEN-1];
        sign_b   = is_signed_b(req_op) && ex_operand2_in[XLEN-1];
        abs_a    = sign_a ? -ex_operand1_in : ex_operand1_in;
        abs_b    = sign_b ? -ex_operand2_in : ex_operand2_in;
        div_zero = is_div(req_op) && (ex_operand2_in == '0);
        div_ovf  = ((req_op == OpDiv) || (req_op == OpRem))
                   && (ex_operand1_in == {1'b1, {(XLEN-1){1'b0}}})
                   && (ex_operand2_in == '1);

        addend  = acc_q[0] ? {1'b0, operand_q} : '0;
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + addend;
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        rem_ge  = rem_sh >= {1'b0, operand_q};
        rem_new = rem_ge ? (rem_sh - {1'b0, operand_q}) : rem_sh;

        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            StIdle: begin
                if (ex_req_valid_in) begin
                    op_d      = req_op;
                    neg_a_d   = sign_a;
                    neg_b_d   = sign_b;
                    cnt_d     = CntW'(XLEN - 1);
                    special_d = div_zero || div_ovf;
                    if (is_div(req_op)) begin
                        operand_d = abs_b;
                        acc_d     = {{XLEN{1'b0}}, abs_a};
                    end else begin
                        operand_d = abs_a;
                        acc_d     = {{XLEN{1'b0}}, abs_b};
                    end
                    if (div_zero) begin
                        acc_d[XLEN-1:0] = req_op[1] ? ex_operand1_in : '1;
                    end else if (div_ovf) begin
                        acc_d[XLEN-1:0] = req_op[1] ? '0 : ex_operand1_in;
                    end
                    state_d = (div_zero || div_ovf) ? StFixup : StCalc;
                end
            end
            StCalc: begin
                if (is_div(op_q)) begin
                    acc_d = {rem_new[XLEN-1:0], acc_q[XLEN-2:0], rem_ge};
                end else begin
                    acc_d = {sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                if (special_q) begin
                    result_d = acc_q[XLEN-1:0];
                end else if (is_div(op_q)) begin
                    result_d = op_q[1] ? rem : quot;
                end else begin
                    result_d = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end
                state_d = StResp;
            end
            StResp: begin
                if (ex_resp_ready_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush beats any accept, commit or response handshake this cycle.
        if (ex_flush_in) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            special_q <= 1'b0;
            operand_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            special_q <= special_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign ex_req_ready_out  = (state_q == StIdle);
    assign ex_resp_valid_out = (state_q == StResp);
    assign ex_mdu_busy_out   = (state_q != StIdle);
    assign ex_mdu_result_out = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative: latency, results, backpressure,
// flush and mid-operation reset, all against hand-computed values.
module tb_mdu_iterative;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic watch = 1'b0;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_req_valid_in   (req_valid),
        .ex_req_ready_out  (req_ready),
        .ex_req_op_in      (req_op),
        .ex_operand1_in    (op1),
        .ex_operand2_in    (op2),
        .ex_flush_in       (flush),
        .ex_resp_valid_out (resp_valid),
        .ex_resp_ready_in  (resp_ready),
        .ex_mdu_result_out (result),
        .ex_mdu_busy_out   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch && resp_valid) pulses++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op and expect the response 'lat' cycles after the accept edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        op1        = a;
        op2        = b;
        resp_ready = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        while (!resp_valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " lat"}, 64'(n), 64'(lat));
        check({tag, " res"}, result, exp);
        @(negedge clk);
        check({tag, " idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        op1        = '0;
        op2        = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 64'(req_ready), 64'd1);
        check("rst valid", 64'(resp_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst result", result, 64'd0);
        rst_n = 1'b1;

        run_op("mul", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 66);
        run_op("mulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66);
        run_op("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu", 3'b101, 64'd100, 64'd7, 64'd14, 66);
        run_op("remu", 3'b111, 64'd100, 64'd7, 64'd2, 66);
        run_op("divu0", 3'b101, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("remu0", 3'b111, 64'd42, 64'd0, 64'd42, 2);
        run_op("divovf", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 2);
        run_op("removf", 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);

        // Backpressure: DIVU 100/7 held in RESP for 10 cycles.
        begin
            int n;
            @(negedge clk);
            req_valid  = 1'b1;
            req_op     = 3'b101;
            op1        = 64'd100;
            op2        = 64'd7;
            resp_ready = 1'b0;
            @(posedge clk);
            n = 1;
            @(negedge clk);
            req_valid = 1'b0;
            while (!resp_valid && n < 200) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            check("bp lat", 64'(n), 64'd66);
            for (int i = 0; i < 10; i++) begin
                check("bp valid", 64'(resp_valid), 64'd1);
                check("bp result", result, 64'd14);
                check("bp reqrdy", 64'(req_ready), 64'd0);
                @(negedge clk);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            check("bp drop", 64'(resp_valid), 64'd0);
            check("bp ready", 64'(req_ready), 64'd1);
        end

        // Flush at T+30 of a DIV.
        watch = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b100;
        op1       = 64'hFFFF_FFFF_FFFF_FFF9;
        op2       = 64'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (29) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush ready", 64'(req_ready), 64'd1);
        check("flush valid", 64'(resp_valid), 64'd0);
        check("flush result", result, 64'd14);
        repeat (80) @(negedge clk);

        // Reset in the middle of a MUL.
        req_valid = 1'b1;
        req_op    = 3'b000;
        op1       = 64'd7;
        op2       = 64'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst ready", 64'(req_ready), 64'd1);
        check("midrst valid", 64'(resp_valid), 64'd0);
        check("midrst result", result, 64'd0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        watch = 1'b0;
        check("no resp pulse", 64'(pulses), 64'd0);

        run_op("post divu", 3'b101, 64'd100, 64'd7, 64'd14, 66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle RV64M multiply/divide responder to the EX stage, which acts as the initiator.
- EX issues an M-extension op on a valid/ready request channel and stalls until this block returns the 64-bit result on a valid/ready response channel.
- Replaces the single-cycle combinational mul/div datapath with a radix-2 shift-add / restoring-division engine that iterates one bit per clock.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- ex_req_valid_in  input  1  request valid from EX.
- ex_req_ready_out  output  1  block can accept a request.
- ex_req_op_in  input  3  RV64M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_operand1_in  input  XLEN  rs1 (multiplicand/dividend).
- ex_operand2_in  input  XLEN  rs2 (multiplier/divisor).
- ex_flush_in  input  1  kill the in-flight op (pipeline flush).
- ex_resp_valid_out  output  1  result available.
- ex_resp_ready_in  input  1  EX consumes result.
- ex_mdu_result_out  output  XLEN  result.
- ex_mdu_busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; ex_req_ready_out=1; ex_resp_valid_out=0; ex_mdu_result_out=0; ex_mdu_busy_out=0.
  - All internal registers cleared; any op in progress is abandoned.
- State machine: IDLE, CALC, FIXUP, RESP.
- Request handshake: accepted when ex_req_valid_in && ex_req_ready_out. ex_req_ready_out is 1 only in IDLE.
- Acceptance at cycle T:
  - Latch op, sign flags and |a|, |b|. Magnitudes are taken only for signed operands: MULH both; MULHSU rs1 only; DIV/REM both.
  - Count=XLEN-1.
  - Next state is CALC, or FIXUP for the special cases below.
- CALC, multiply:
  - 128-bit accumulator.
  - Each cycle: if multiplier LSB is 1, add multiplicand to the upper half, then shift right 1.
- CALC, divide:
  - Restoring division: shift {rem,quot} left 1; if rem>=|b|, subtract and set quot LSB.
  - Runs exactly XLEN cycles (T+1..T+64); count decrements and CALC exits to FIXUP when count==0.
- FIXUP (T+65):
  - Negate product if the operand signs differ.
  - Quotient negates if the dividend and divisor signs differ; remainder takes the dividend's sign.
  - Select low/high half or quotient/remainder; register into ex_mdu_result_out.
  - Go to RESP.
- RESP:
  - ex_resp_valid_out=1 from T+66; result held stable while ex_resp_ready_in is 0.
  - On ex_resp_ready_in=1: valid drops next cycle, return to IDLE, ready=1 next cycle.
  - No back-to-back accept in the same cycle as the response handshake.
- Special cases (skip CALC; resp_valid at T+2):
  - Divisor==0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - DIV overflow (-2^63 / -1): quotient -2^63; REM gives 0.
- Flush:
  - ex_flush_in=1 in any state forces IDLE next cycle with resp_valid=0.
  - Flush wins over a simultaneous request (no accept) and over a simultaneous response handshake.
- Results are never partially updated; ex_mdu_result_out changes only in FIXUP or at reset.
- Arithmetic is mod 2^XLEN for results; all internal arithmetic is unsigned on magnitudes.

Decomposition:
- Package mdu_pkg holds:
  - XLEN default.
  - mdu_op_e enum with the 8 funct3 codes.
  - mdu_state_e {IDLE,CALC,FIXUP,RESP}.
  - Helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- Single module; no sub-module is warranted, since the shared shifter/adder datapath is inline in one always_ff plus one always_comb.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, resp_valid exactly at T+66.
- MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> 1; MULH a=-1, b=-1 -> 0; MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
- DIVU a=42, b=0 -> all ones at T+2; REMU -> 42; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
- Backpressure: hold ex_resp_ready_in=0 for 10 cycles in RESP -> valid and result stable, req_ready=0; raise ready -> IDLE and req_ready=1 next cycle.
- Flush at T+30 of DIV, then rst_n=0 mid-CALC on a second op -> both return to IDLE, no resp_valid pulse, outputs at reset values, next request completes correctly.
